pulse_meter: RTL

PULSE_METER -- requirements
Module: pulse_meter

---
 rtl/pulse_meter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pulse_meter.sv
// pulse_meter: measures the interval, in clock cycles, between successive
// pulses on in_pulse and offers each result on a valid/ready output.
// Optional input conditioning is enabled with macro PULSE_METER_SYNC_EN
// (2-flop synchronizer plus rising-edge detector); without it in_pulse is
// used directly as a same-clock strobe.
// rst is asynchronous and active-low; clr is the synchronous clear.
module pulse_meter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_pulse,
  input  logic         clr,
  output logic [W-1:0] period,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         timeout,
  output logic         overrun
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [W-1:0] TMO_C  = W'(TIMEOUT);
  localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_C = {W{1'b0}};

  state_t       state_r;
  state_t       state_nxt_s;
  logic [W-1:0] cnt_r;
  logic [W-1:0] period_r;
  logic         valid_r;
  logic         timeout_r;
  logic         overrun_r;
  logic         pulse_s;
  logic         start_s;
  logic         load_s;
  logic         inc_s;
  logic         expire_s;

`ifdef PULSE_METER_SYNC_EN
  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronize in_pulse and keep the previous level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= in_pulse;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // A high level of any length yields a single pulse on its rising edge.
  assign pulse_s = sync2_r & ~prev_r;
`else
  // Same-clock strobe: every high cycle is a pulse.
  assign pulse_s = in_pulse;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clr wins over any pulse in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (pulse_s) state_nxt_s = MEASURE;
          else         state_nxt_s = IDLE;
        end
        MEASURE: begin
          if (pulse_s)              state_nxt_s = MEASURE;
          else if (cnt_r == TMO_C)  state_nxt_s = IDLE;
          else                      state_nxt_s = MEASURE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Control decode: start, load result, count, or expire.
  always_comb begin
    start_s  = 1'b0;
    load_s   = 1'b0;
    inc_s    = 1'b0;
    expire_s = 1'b0;
    if (clr) begin
      start_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          start_s = pulse_s;
        end
        MEASURE: begin
          if (pulse_s)             load_s   = 1'b1;
          else if (cnt_r == TMO_C) expire_s = 1'b1;
          else                     inc_s    = 1'b1;
        end
        default: start_s = 1'b0;
      endcase
    end
  end

  // Interval counter: 1 after a pulse, saturates by expiring at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= ZERO_C;
    end else if (clr || expire_s) begin
      cnt_r <= ZERO_C;
    end else if (start_s || load_s) begin
      cnt_r <= ONE_C;
    end else if (inc_s) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Timeout strobe, high for the single cycle after expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= expire_s;
    end
  end

  // Result holding register with valid/ready handshake and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_r  <= ZERO_C;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (clr) begin
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (load_s) begin
      if (!valid_r || period_ready) begin
        period_r <= cnt_r;
        valid_r  <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (valid_r && period_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign period       = period_r;
  assign period_valid = valid_r;
  assign timeout      = timeout_r;
  assign overrun      = overrun_r;

endmodule
